// File: rtl/video_sprite_renderer.sv
// Pixel stage: draws one 8x8 1bpp sprite scaled by 2^SCALE_LOG2 over a background, with per-frame bounce motion and a sticky frame IRQ.
// 1-cycle latency from inputs to rgb/syncs; no backpressure. Define CHECKER_BG_EN for a 32x32 checkerboard background.
`timescale 1ns/1ps
module video_sprite_renderer #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SCALE_LOG2 = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  hpos,
  input  logic [9:0]  vpos,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        display_on,
  input  logic [3:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  input  logic        cfg_we,
  output logic [15:0] cfg_rdata,
  output logic [5:0]  rgb,
  output logic        hsync_o,
  output logic        vsync_o,
  output logic        frame_irq
);

  localparam int          W     = 8 << SCALE_LOG2;
  localparam logic [10:0] W11   = 11'(W);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - W);
  localparam logic [9:0]  H_END = 10'(H_ACTIVE);
  localparam logic [9:0]  V_END = 10'(V_ACTIVE);

  typedef enum logic {FWD = 1'b0, REV = 1'b1} dir_t;

  logic [2:0]  ctrl;
  logic [5:0]  bg;
  logic [5:0]  fg;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [7:0]  vel;
  logic [63:0] bitmap;
  logic [15:0] frame_cnt;
  dir_t        dir_x;
  dir_t        dir_y;

  logic        frame_tick;
  logic        wr_x;
  logic        wr_y;
  logic        irq_clr;
  logic [10:0] step_x;
  logic [10:0] step_y;

  assign frame_tick = (hpos == 10'd0) && (vpos == V_END);
  assign wr_x       = cfg_we && (cfg_addr == 4'd3);
  assign wr_y       = cfg_we && (cfg_addr == 4'd4);
  assign irq_clr    = cfg_we && (cfg_addr == 4'd10) && cfg_wdata[0];

  // Returns {rev, next_pos}; a zero magnitude freezes both position and direction.
  function automatic logic [10:0] axis_step(input logic [9:0] pos, input logic rev,
                                            input logic [3:0] mag, input logic [10:0] lim);
    logic [10:0] sum;
    sum       = {1'b0, pos} + {7'd0, mag};
    axis_step = {rev, pos};
    if (mag != 4'd0) begin
      if (!rev) begin
        if (sum > lim) axis_step = {1'b1, lim[9:0]};
        else           axis_step = {1'b0, sum[9:0]};
      end else begin
        if ({6'd0, mag} > pos) axis_step = {1'b0, 10'd0};
        else                   axis_step = {1'b1, pos - {6'd0, mag}};
      end
    end
  endfunction

  assign step_x = axis_step(x, dir_x == REV, vel[3:0], X_MAX);
  assign step_y = axis_step(y, dir_y == REV, vel[7:4], Y_MAX);

  // Sprite hit test at 11 bits so X+W never wraps.
  logic [10:0] h11, v11, x11, y11;
  logic        in_x, in_y;
  logic [2:0]  col, row;
  logic        sprite_hit;

  assign h11 = {1'b0, hpos};
  assign v11 = {1'b0, vpos};
  assign x11 = {1'b0, x};
  assign y11 = {1'b0, y};
  assign in_x = (h11 >= x11) && (h11 < x11 + W11) && (hpos < H_END);
  assign in_y = (v11 >= y11) && (v11 < y11 + W11) && (vpos < V_END);
  assign col  = 3'((h11 - x11) >> SCALE_LOG2);
  assign row  = 3'((v11 - y11) >> SCALE_LOG2);
  assign sprite_hit = in_x && in_y && bitmap[{row, col}];

  logic [5:0] bg_px;
  logic [5:0] rgb_nxt;

  always_comb begin
    bg_px = bg;
`ifdef CHECKER_BG_EN
    if (hpos[5] ^ vpos[5]) bg_px = ~bg;
`endif
    rgb_nxt = 6'd0;
    if (display_on && ctrl[0]) rgb_nxt = sprite_hit ? fg : bg_px;
  end

  always_comb begin
    cfg_rdata = 16'd0;
    case (cfg_addr)
      4'd0:    cfg_rdata = {13'd0, ctrl};
      4'd1:    cfg_rdata = {10'd0, bg};
      4'd2:    cfg_rdata = {10'd0, fg};
      4'd3:    cfg_rdata = {6'd0, x};
      4'd4:    cfg_rdata = {6'd0, y};
      4'd5:    cfg_rdata = {8'd0, vel};
      4'd6:    cfg_rdata = bitmap[15:0];
      4'd7:    cfg_rdata = bitmap[31:16];
      4'd8:    cfg_rdata = bitmap[47:32];
      4'd9:    cfg_rdata = bitmap[63:48];
      4'd11:   cfg_rdata = frame_cnt;
      default: cfg_rdata = 16'd0;
    endcase
  end

  // Registers, motion FSM and IRQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl      <= 3'd0;
      bg        <= 6'd0;
      fg        <= 6'h3F;
      x         <= 10'd0;
      y         <= 10'd0;
      vel       <= 8'd0;
      bitmap    <= 64'd0;
      frame_cnt <= 16'd0;
      dir_x     <= FWD;
      dir_y     <= FWD;
      frame_irq <= 1'b0;
    end else begin
      if (frame_tick) frame_cnt <= frame_cnt + 16'd1;

      // A CPU write to a position wins over motion and leaves that axis' direction alone.
      if (frame_tick && ctrl[1]) begin
        if (!wr_x) begin
          x     <= step_x[9:0];
          dir_x <= dir_t'(step_x[10]);
        end
        if (!wr_y) begin
          y     <= step_y[9:0];
          dir_y <= dir_t'(step_y[10]);
        end
      end

      if (cfg_we) begin
        case (cfg_addr)
          4'd0:    ctrl <= cfg_wdata[2:0];
          4'd1:    bg   <= cfg_wdata[5:0];
          4'd2:    fg   <= cfg_wdata[5:0];
          4'd3:    x    <= cfg_wdata[9:0];
          4'd4:    y    <= cfg_wdata[9:0];
          4'd5:    vel  <= cfg_wdata[7:0];
          4'd6:    bitmap[15:0]  <= cfg_wdata;
          4'd7:    bitmap[31:16] <= cfg_wdata;
          4'd8:    bitmap[47:32] <= cfg_wdata;
          4'd9:    bitmap[63:48] <= cfg_wdata;
          default: ;
        endcase
      end

      if (frame_tick && ctrl[2]) frame_irq <= 1'b1;
      else if (irq_clr)          frame_irq <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb     <= 6'd0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      rgb     <= rgb_nxt;
      hsync_o <= hsync;
      vsync_o <= vsync;
    end
  end

endmodule

// File: tb/tb_video_sprite_renderer.sv
// Self-checking bench for video_sprite_renderer: directed scenarios plus randomized pixels and motion against a behavioural model.
`timescale 1ns/1ps
module tb_video_sprite_renderer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hpos, vpos;
  logic        hsync, vsync, display_on;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_wdata;
  logic        cfg_we;
  logic [15:0] cfg_rdata;
  logic [5:0]  rgb;
  logic        hsync_o, vsync_o, frame_irq;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  bit         m_en, m_auto;
  logic [5:0] m_bg, m_fg;
  int         m_x, m_y, m_dx, m_dy;
  bit         m_fwd_x, m_fwd_y;
  logic [7:0] m_rows [8];
  int         m_frames;

  video_sprite_renderer dut (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .hsync(hsync), .vsync(vsync),
    .display_on(display_on), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_we(cfg_we),
    .cfg_rdata(cfg_rdata), .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .frame_irq(frame_irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_bg = 6'h00; m_fg = 6'h3F;
    m_x = 0; m_y = 0; m_dx = 0; m_dy = 0; m_fwd_x = 1; m_fwd_y = 1; m_frames = 0;
    for (int i = 0; i < 8; i++) m_rows[i] = 8'h00;
  endtask

  task automatic model_write(input logic [3:0] a, input logic [15:0] d);
    int k;
    k = int'(a) - 6;
    case (a)
      4'd0: begin m_en = d[0]; m_auto = d[1]; end
      4'd1: m_bg = d[5:0];
      4'd2: m_fg = d[5:0];
      4'd3: m_x = int'(d[9:0]);
      4'd4: m_y = int'(d[9:0]);
      4'd5: begin m_dx = int'(d[3:0]); m_dy = int'(d[7:4]); end
      4'd6, 4'd7, 4'd8, 4'd9: begin m_rows[2*k] = d[7:0]; m_rows[2*k+1] = d[15:8]; end
      default: ;
    endcase
  endtask

  task automatic step_axis(inout int pos, inout bit fwd, input int mag, input int lim);
    if (mag == 0) return;
    if (fwd) begin
      if (pos + mag > lim) begin pos = lim; fwd = 0; end
      else pos = pos + mag;
    end else begin
      if (mag > pos) begin pos = 0; fwd = 1; end
      else pos = pos - mag;
    end
  endtask

  function automatic logic [5:0] ref_pixel(input int h, input int v, input bit de);
    logic [7:0] bits;
    logic [5:0] b;
    if (!de || !m_en) return 6'h00;
    if (h >= m_x && h < m_x + 32 && v >= m_y && v < m_y + 32 && h < 640 && v < 480) begin
      bits = m_rows[(v - m_y) / 4];
      if (bits[(h - m_x) / 4]) return m_fg;
    end
    b = m_bg;
`ifdef CHECKER_BG_EN
    if (((h / 32) + (v / 32)) % 2 == 1) b = ~m_bg;
`endif
    return b;
  endfunction

  task automatic cfg_write(input logic [3:0] a, input logic [15:0] d);
    cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    model_write(a, d);
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [15:0] d);
    cfg_addr = a; #1;
    d = cfg_rdata;
  endtask

  task automatic frame_pulse();
    hpos = 10'd0; vpos = 10'd480;
    @(posedge clk); #1;
    hpos = 10'd1; vpos = 10'd0;
    m_frames++;
    if (m_auto) begin
      step_axis(m_x, m_fwd_x, m_dx, 608);
      step_axis(m_y, m_fwd_y, m_dy, 448);
    end
  endtask

  task automatic test_reset();
    logic [15:0] d;
    rst_n = 1'b0; hsync = 1'b1; vsync = 1'b1; display_on = 1'b1;
    hpos = 10'd1; vpos = 10'd0; cfg_addr = 4'd0; cfg_wdata = 16'd0; cfg_we = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    tests++; if (rgb !== 6'h00) begin fails++; $display("FAIL reset_rgb got %h want 00", rgb); end
    tests++; if ({hsync_o, vsync_o} !== 2'b00) begin fails++; $display("FAIL reset_syncs got %b want 00", {hsync_o, vsync_o}); end
    tests++; if (frame_irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b want 0", frame_irq); end
    cfg_read(4'd2, d);
    tests++; if (d !== 16'h003F) begin fails++; $display("FAIL reset_fg got %h want 003F", d); end
    for (int a = 0; a < 16; a++) begin
      if (a == 2) continue;
      cfg_read(4'(a), d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reset_reg%0d got %h want 0000", a, d); end
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++; if ({hsync_o, vsync_o} !== 2'b11) begin fails++; $display("FAIL post_reset_syncs got %b want 11", {hsync_o, vsync_o}); end
    hsync = 1'b0; vsync = 1'b0; display_on = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_latency();
    cfg_write(4'd0, 16'h0001);
    cfg_write(4'd1, 16'h0001);
    hpos = 10'd300; vpos = 10'd300; display_on = 1'b1; hsync = 1'b0;
    @(posedge clk); #1;
    hsync = 1'b1;
    #2;
    tests++; if (hsync_o !== 1'b0) begin fails++; $display("FAIL lat_hsync_early got %b want 0", hsync_o); end
    @(posedge clk); #1;
    tests++; if (hsync_o !== 1'b1) begin fails++; $display("FAIL lat_hsync_n1 got %b want 1", hsync_o); end
    tests++; if (rgb !== 6'h01) begin fails++; $display("FAIL lat_rgb got %h want 01", rgb); end
    vsync = 1'b1; display_on = 1'b0;
    @(posedge clk); #1;
    tests++; if (vsync_o !== 1'b1) begin fails++; $display("FAIL lat_vsync got %b want 1", vsync_o); end
    tests++; if (rgb !== 6'h00) begin fails++; $display("FAIL lat_blank got %h want 00", rgb); end
    hsync = 1'b0; vsync = 1'b0;
  endtask

  task automatic test_regs();
    logic [15:0] d;
    cfg_write(4'd1, 16'hFFFF); cfg_read(4'd1, d);
    tests++; if (d !== 16'h003F) begin fails++; $display("FAIL reg_bg got %h want 003F", d); end
    cfg_write(4'd2, 16'hFFEA); cfg_read(4'd2, d);
    tests++; if (d !== 16'h002A) begin fails++; $display("FAIL reg_fg got %h want 002A", d); end
    cfg_write(4'd5, 16'hABCD); cfg_read(4'd5, d);
    tests++; if (d !== 16'h00CD) begin fails++; $display("FAIL reg_vel got %h want 00CD", d); end
    cfg_write(4'd7, 16'h1234); cfg_read(4'd7, d);
    tests++; if (d !== 16'h1234) begin fails++; $display("FAIL reg_bitmap got %h want 1234", d); end
    cfg_write(4'd4, 16'hFC11); cfg_read(4'd4, d);
    tests++; if (d !== 16'h0011) begin fails++; $display("FAIL reg_y got %h want 0011", d); end
    for (int a = 12; a < 16; a++) begin
      cfg_write(4'(a), 16'hFFFF); cfg_read(4'(a), d);
      tests++; if (d !== 16'h0000) begin fails++; $display("FAIL reg_unmapped%0d got %h want 0000", a, d); end
    end
    cfg_write(4'd5, 16'h0000);
    cfg_write(4'd7, 16'h0000);
    cfg_write(4'd4, 16'h0000);
  endtask

  task automatic test_sprite_hit();
    logic [5:0] exp;
    cfg_write(4'd0, 16'h0001);
    cfg_write(4'd1, 16'h0001);
    cfg_write(4'd2, 16'h0030);
    cfg_write(4'd3, 16'd100);
    cfg_write(4'd4, 16'd50);
    cfg_write(4'd6, 16'h0001);
    display_on = 1'b1;
    for (int v = 50; v < 54; v++)
      for (int h = 100; h < 104; h++) begin
        hpos = 10'(h); vpos = 10'(v);
        @(posedge clk); #1;
        tests++; if (rgb !== 6'h30) begin fails++; $display("FAIL hit_%0d_%0d got %h want 30", h, v, rgb); end
      end
    hpos = 10'd104; vpos = 10'd50; exp = ref_pixel(104, 50, 1);
    @(posedge clk); #1;
    tests++; if (rgb !== exp || exp !== 6'h01) begin fails++; $display("FAIL miss_104_50 got %h want 01", rgb); end
    hpos = 10'd99; exp = ref_pixel(99, 50, 1);
    @(posedge clk); #1;
    tests++; if (rgb !== exp) begin fails++; $display("FAIL miss_99_50 got %h want %h", rgb, exp); end
  endtask

  task automatic test_checker();
    logic [5:0] exp;
    cfg_write(4'd1, 16'h0000);
    hpos = 10'd32; vpos = 10'd0; display_on = 1'b1;
`ifdef CHECKER_BG_EN
    exp = 6'h3F;
`else
    exp = 6'h00;
`endif
    @(posedge clk); #1;
    tests++; if (rgb !== exp) begin fails++; $display("FAIL checker_32_0 got %h want %h", rgb, exp); end
  endtask

  task automatic test_random_pixels();
    logic [5:0] exp;
    for (int s = 0; s < 4; s++) begin
      cfg_write(4'd0, (s == 2) ? 16'h0000 : 16'h0001);
      cfg_write(4'd1, 16'($urandom));
      cfg_write(4'd2, 16'($urandom));
      cfg_write(4'd3, (s == 3) ? 16'd620 : 16'($urandom_range(0, 639)));
      cfg_write(4'd4, (s == 1) ? 16'd465 : 16'($urandom_range(0, 479)));
      for (int k = 6; k < 10; k++) cfg_write(4'(k), 16'($urandom));
      for (int i = 0; i < 60; i++) begin
        int h, v;
        bit de;
        if ($urandom_range(0, 9) < 7) begin
          h = m_x - 4 + int'($urandom_range(0, 40));
          v = m_y - 4 + int'($urandom_range(0, 40));
        end else begin
          h = int'($urandom_range(0, 799));
          v = int'($urandom_range(0, 524));
        end
        if (h < 0) h = 0;
        if (h > 1023) h = 1023;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        if (h == 0 && v == 480) v = 479;
        de = ($urandom_range(0, 4) != 0);
        hpos = 10'(h); vpos = 10'(v); display_on = de;
        exp = ref_pixel(h, v, de);
        @(posedge clk); #1;
        tests++; if (rgb !== exp) begin fails++; $display("FAIL rand_pixel(%0d,%0d,de=%0d) got %h want %h", h, v, de, rgb, exp); end
      end
    end
    display_on = 1'b0; hpos = 10'd1; vpos = 10'd0;
  endtask

  task automatic test_bounce_right();
    logic [15:0] d;
    cfg_write(4'd5, 16'h0005);
    cfg_write(4'd3, 16'd600);
    cfg_write(4'd4, 16'd10);
    cfg_write(4'd0, 16'h0003);
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd605) begin fails++; $display("FAIL bounce_f1 got %0d want 605", d); end
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd608) begin fails++; $display("FAIL bounce_f2 got %0d want 608", d); end
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd603) begin fails++; $display("FAIL bounce_f3 got %0d want 603", d); end
    cfg_read(4'd4, d);
    tests++; if (d !== 16'd10) begin fails++; $display("FAIL bounce_y_still got %0d want 10", d); end
  endtask

  task automatic test_left_override();
    logic [15:0] d;
    cfg_write(4'd3, 16'd2);
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd0) begin fails++; $display("FAIL left_clamp got %0d want 0", d); end
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd5) begin fails++; $display("FAIL left_fwd got %0d want 5", d); end
    hpos = 10'd0; vpos = 10'd480;
    cfg_addr = 4'd3; cfg_wdata = 16'd300; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; hpos = 10'd1; vpos = 10'd0;
    m_frames++; m_x = 300;
    step_axis(m_y, m_fwd_y, m_dy, 448);
    cfg_read(4'd3, d);
    tests++; if (d !== 16'd300) begin fails++; $display("FAIL override_x got %0d want 300", d); end
    frame_pulse(); cfg_read(4'd3, d);
    tests++; if (d !== 16'd305) begin fails++; $display("FAIL override_dir got %0d want 305", d); end
  endtask

  task automatic test_random_motion();
    logic [15:0] dx_r, dy_r;
    cfg_write(4'd3, 16'($urandom_range(580, 620)));
    cfg_write(4'd4, 16'($urandom_range(420, 470)));
    for (int f = 0; f < 40; f++) begin
      if (f % 5 == 0) cfg_write(4'd5, 16'($urandom_range(0, 255)));
      frame_pulse();
      cfg_read(4'd3, dx_r);
      cfg_read(4'd4, dy_r);
      tests++; if (dx_r !== 16'(m_x)) begin fails++; $display("FAIL motion_x f%0d got %0d want %0d", f, dx_r, m_x); end
      tests++; if (dy_r !== 16'(m_y)) begin fails++; $display("FAIL motion_y f%0d got %0d want %0d", f, dy_r, m_y); end
    end
    cfg_read(4'd11, dx_r);
    tests++; if (dx_r !== 16'(m_frames)) begin fails++; $display("FAIL frame_count got %0d want %0d", dx_r, m_frames); end
    cfg_write(4'd0, 16'h0000);
  endtask

  task automatic test_irq();
    logic [15:0] d;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    cfg_write(4'd0, 16'h0004);
    frame_pulse();
    frame_pulse();
    tests++; if (frame_irq !== 1'b1) begin fails++; $display("FAIL irq_set got %b want 1", frame_irq); end
    cfg_read(4'd11, d);
    tests++; if (d !== 16'd2) begin fails++; $display("FAIL irq_count got %0d want 2", d); end
    cfg_write(4'd10, 16'h0001);
    tests++; if (frame_irq !== 1'b0) begin fails++; $display("FAIL irq_clear got %b want 0", frame_irq); end
    hpos = 10'd0; vpos = 10'd480;
    cfg_addr = 4'd10; cfg_wdata = 16'h0001; cfg_we = 1'b1;
    @(posedge clk); #1;
    cfg_we = 1'b0; hpos = 10'd1; vpos = 10'd0;
    tests++; if (frame_irq !== 1'b1) begin fails++; $display("FAIL irq_set_wins got %b want 1", frame_irq); end
    cfg_write(4'd0, 16'h0000);
    cfg_write(4'd10, 16'h0001);
    frame_pulse();
    tests++; if (frame_irq !== 1'b0) begin fails++; $display("FAIL irq_disabled got %b want 0", frame_irq); end
    cfg_read(4'd11, d);
    tests++; if (d !== 16'd4) begin fails++; $display("FAIL irq_count_always got %0d want 4", d); end
  endtask

  task automatic test_async_reset();
    logic [15:0] d;
    cfg_write(4'd0, 16'h0005);
    cfg_write(4'd1, 16'h003F);
    cfg_write(4'd3, 16'd77);
    frame_pulse();
    hpos = 10'd300; vpos = 10'd300; display_on = 1'b1; hsync = 1'b1; vsync = 1'b1;
    cfg_addr = 4'd3;
    @(posedge clk); #1;
    tests++; if (rgb !== ref_pixel(300, 300, 1) || frame_irq !== 1'b1) begin
      fails++; $display("FAIL arst_pre rgb=%h irq=%b want %h/1", rgb, frame_irq, ref_pixel(300, 300, 1));
    end
    #1 rst_n = 1'b0;
    #1;
    tests++; if ({rgb, hsync_o, vsync_o, frame_irq} !== 9'd0) begin
      fails++; $display("FAIL arst_outputs got rgb=%h hs=%b vs=%b irq=%b want all 0", rgb, hsync_o, vsync_o, frame_irq);
    end
    tests++; if (cfg_rdata !== 16'd0) begin fails++; $display("FAIL arst_x got %0d want 0", cfg_rdata); end
    cfg_read(4'd2, d);
    tests++; if (d !== 16'h003F) begin fails++; $display("FAIL arst_fg got %h want 003F", d); end
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    tests++; if (hsync_o !== 1'b1 || rgb !== 6'h00) begin
      fails++; $display("FAIL arst_release got hs=%b rgb=%h want 1/00", hsync_o, rgb);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_regs();
    test_sprite_hit();
    test_checker();
    test_random_pixels();
    test_bounce_right();
    test_left_override();
    test_random_motion();
    test_irq();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
